tilexy_ack_fifo: RTL and testbench

//  Return-path (ack) router for one mesh dimension of a tile. Takes completion acks from the local

---
 rtl/tilexy_ack_fifo_pkg.sv | 39 +++
 rtl/tilexy_ack_fifo_q.sv | 53 +++++
 rtl/tilexy_ack_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_tilexy_ack_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tilexy_ack_fifo_pkg.sv
// Shared types and helpers for the tile ack return-path router.
package tilexy_ack_fifo_pkg;

   localparam int unsigned NPKT_W = 123;
   localparam int unsigned ADDR_W = 43;
   localparam int unsigned DATA_W = 74;
   localparam int unsigned PA_W   = 33;
   localparam int unsigned CRD_W  = 5;
   localparam int unsigned SZ_W   = 2;

   // Narrow link packet, msb first: rsvd[122] snd[121] addr[120:88] sz[87:86]
   // ty[85:81] tx[80:76] ydone[75] xdone[74] data[73:0]
   typedef struct packed {
      logic              rsvd;
      logic              snd;
      logic [PA_W-1:0]   addr;
      logic [SZ_W-1:0]   sz;
      logic [CRD_W-1:0]  ty;
      logic [CRD_W-1:0]  tx;
      logic              ydone;
      logic              xdone;
      logic [DATA_W-1:0] data;
   } npkt_t;

   // Coordinate this link routes on: X for links 0/1, Y for links 2/3.
   function automatic logic [CRD_W-1:0] route_key(input npkt_t p, input int unsigned idx);
      return (idx < 2) ? p.tx : p.ty;
   endfunction

   // Packet as it goes on the wire: valid set, reserved bit cleared.
   function automatic npkt_t to_link(input npkt_t p);
      npkt_t o;
      o      = p;
      o.snd  = 1'b1;
      o.rsvd = 1'b0;
      return o;
   endfunction

endpackage

// File: rtl/tilexy_ack_fifo_q.sv
// Synchronous packet FIFO; pushes into a full queue are dropped.
module tilexy_ack_fifo_q
   import tilexy_ack_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  npkt_t                    din,
   output npkt_t                    head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   npkt_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];
   assign count   = cnt;

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tilexy_ack_fifo.sv
// Ack return-path router for one mesh dimension: local injection, transit and eject.
module tilexy_ack_fifo
   import tilexy_ack_fifo_pkg::*;
#(
   parameter int unsigned TILE_X   = 0,
   parameter int unsigned TILE_Y   = 0,
   parameter int unsigned IDX      = 0,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_SLACK = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rsp_en,
   input  logic [DATA_W-1:0]       rsp_data,
   input  logic [ADDR_W-1:0]       rsp_addr,
   input  logic [SZ_W-1:0]         rsp_sz,
   output logic                    rsp_stall,
   input  logic [1:0][NPKT_W-1:0]  lnk_in,
   output logic [1:0]              lnk_in_full,
   output logic [1:0][NPKT_W-1:0]  lnk_out,
   input  logic [1:0]              lnk_out_full,
   output logic                    ack_valid,
   input  logic                    ack_ready,
   output logic [DATA_W-1:0]       ack_data,
   output logic [ADDR_W-1:0]       ack_addr,
   output logic [SZ_W-1:0]         ack_sz,
   output logic                    ovf_err
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned OW    = AW + 2;
   localparam logic [OW-1:0]    AF_TH = OW'(DEPTH - AF_SLACK);
   localparam logic [CRD_W-1:0] OWN   = CRD_W'((IDX < 2) ? TILE_X : TILE_Y);
   // Queue slots: transit back/fwd share the link index, eject queues follow.
   localparam int unsigned QT0 = 0;
   localparam int unsigned QT1 = 1;
   localparam int unsigned QE0 = 2;
   localparam int unsigned QE1 = 3;

   npkt_t         in_pkt [2];
   logic [1:0]    in_ej;
   logic [1:0]    in_tr;
   npkt_t         loc_pkt;
   npkt_t         hold_pkt;
   logic          hold_valid;
   logic [CRD_W-1:0] hold_key;
   logic          hold_fwd;
   logic          hold_back;
   logic          hold_ej;
   logic          accept;
   logic [3:0]    q_push;
   logic [3:0]    q_pop;
   logic [3:0]    q_full;
   logic [3:0]    q_empty;
   logic [3:0]    q_ovf;
   npkt_t         q_din  [4];
   npkt_t         q_head [4];
   logic [AW:0]   q_cnt  [4];
   logic [OW-1:0] q_nocc [4];
   logic          rr_q;
   logic          lock_q;
   logic          lock_sel_q;
   logic          grant;
   npkt_t         ack_pkt;

   // Classify incoming link packets as eject or pass-through.
   always_comb begin
      in_ej = '0;
      in_tr = '0;
      for (int p = 0; p < 2; p++) begin
         in_pkt[p] = lnk_in[p];
         in_ej[p]  = in_pkt[p].snd & (route_key(in_pkt[p], IDX) == OWN);
         in_tr[p]  = in_pkt[p].snd & (route_key(in_pkt[p], IDX) != OWN);
      end
   end

   // Format a local ack as a link packet.
   always_comb begin
      loc_pkt       = '0;
      loc_pkt.data  = rsp_data;
      loc_pkt.xdone = (IDX < 2);
      loc_pkt.ydone = (IDX >= 2);
      loc_pkt.tx    = rsp_addr[PA_W +: CRD_W];
      loc_pkt.ty    = rsp_addr[PA_W+CRD_W +: CRD_W];
      loc_pkt.sz    = rsp_sz;
      loc_pkt.addr  = rsp_addr[PA_W-1:0];
      loc_pkt.snd   = 1'b1;
   end

   // Queue write steering; transit wins, the hold reg fills in idle slots.
   always_comb begin
      q_push    = '0;
      q_din[0]  = hold_pkt;
      q_din[1]  = hold_pkt;
      q_din[2]  = hold_pkt;
      q_din[3]  = hold_pkt;
      accept    = 1'b0;
      hold_key  = route_key(hold_pkt, IDX);
      hold_ej   = (hold_key == OWN);
      hold_fwd  = (hold_key > OWN);
      hold_back = (hold_key < OWN);
      if (hold_valid) begin
         if (hold_fwd)       accept = ~in_tr[0] & ~q_full[QT1];
         else if (hold_back) accept = ~in_tr[1] & ~q_full[QT0];
         else                accept = ~in_ej[0] & ~q_full[QE0];
      end
      q_push[QT0] = in_tr[1] | (accept & hold_back);
      q_push[QT1] = in_tr[0] | (accept & hold_fwd);
      q_push[QE0] = in_ej[0] | (accept & hold_ej);
      q_push[QE1] = in_ej[1];
      if (in_tr[1]) q_din[QT0] = in_pkt[1];
      if (in_tr[0]) q_din[QT1] = in_pkt[0];
      if (in_ej[0]) q_din[QE0] = in_pkt[0];
      q_din[QE1] = in_pkt[1];
      q_ovf = q_push & q_full;
   end

   assign rsp_stall = hold_valid & ~accept;

   // One-entry local hold register; refills only when empty or draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_pkt   <= '0;
      end else if (~hold_valid | accept) begin
         hold_valid <= rsp_en;
         if (rsp_en) hold_pkt <= loc_pkt;
      end
   end

   // Round-robin eject grant with lock while the consumer stalls; queue pops.
   always_comb begin
      grant = 1'b0;
      if (lock_q)    grant = lock_sel_q;
      else if (rr_q) grant = ~q_empty[QE1];
      else           grant = q_empty[QE0];
      ack_valid = grant ? ~q_empty[QE1] : ~q_empty[QE0];
      ack_pkt   = '0;
      if (ack_valid) ack_pkt = grant ? q_head[QE1] : q_head[QE0];
      q_pop      = '0;
      q_pop[QT0] = ~q_empty[QT0] & ~lnk_out_full[0];
      q_pop[QT1] = ~q_empty[QT1] & ~lnk_out_full[1];
      q_pop[QE0] = ack_valid & ack_ready & ~grant;
      q_pop[QE1] = ack_valid & ack_ready & grant;
   end

   assign ack_data = ack_pkt.data;
   assign ack_addr = {ack_pkt.ty, ack_pkt.tx, ack_pkt.addr};
   assign ack_sz   = ack_pkt.sz;

   // Arbiter state: pointer flips after every handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q       <= 1'b0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
      end else begin
         lock_q     <= ack_valid & ~ack_ready;
         lock_sel_q <= grant;
         if (ack_valid & ack_ready) rr_q <= ~grant;
      end
   end

   // Next-cycle occupancy for early backpressure.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         q_nocc[i] = OW'(q_cnt[i]) + OW'(q_push[i] & ~q_full[i]) - OW'(q_pop[i]);
      end
   end

   // Link output registers, almost-full flags and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         lnk_out     <= '0;
         lnk_in_full <= '0;
         ovf_err     <= 1'b0;
      end else begin
         lnk_in_full[0] <= (q_nocc[QT1] >= AF_TH) | (q_nocc[QE0] >= AF_TH);
         lnk_in_full[1] <= (q_nocc[QT0] >= AF_TH) | (q_nocc[QE1] >= AF_TH);
         for (int d = 0; d < 2; d++) begin
            lnk_out[d] <= q_pop[d] ? to_link(q_head[d]) : '0;
         end
         if (|q_ovf) ovf_err <= 1'b1;
      end
   end

   ovf_check: assert property (@(posedge clk) disable iff (rst) q_ovf == 4'b0);

   for (genvar i = 0; i < 4; i++) begin : g_q
      tilexy_ack_fifo_q #(.DEPTH(DEPTH)) u_q (
         .clk   (clk),
         .rst   (rst),
         .push  (q_push[i]),
         .pop   (q_pop[i]),
         .din   (q_din[i]),
         .head  (q_head[i]),
         .count (q_cnt[i]),
         .full  (q_full[i]),
         .empty (q_empty[i])
      );
   end

endmodule

// File: tb/tb_tilexy_ack_fifo.sv
// Directed bench for tilexy_ack_fifo on link 0 of tile X=3.
module tb_tilexy_ack_fifo;

   logic               clk;
   logic               rst;
   logic               rsp_en;
   logic [73:0]        rsp_data;
   logic [42:0]        rsp_addr;
   logic [1:0]         rsp_sz;
   logic               rsp_stall;
   logic [1:0][122:0]  lnk_in;
   logic [1:0]         lnk_in_full;
   logic [1:0][122:0]  lnk_out;
   logic [1:0]         lnk_out_full;
   logic               ack_valid;
   logic               ack_ready;
   logic [73:0]        ack_data;
   logic [42:0]        ack_addr;
   logic [1:0]         ack_sz;
   logic               ovf_err;

   int n_checks = 0;
   int n_errors = 0;

   tilexy_ack_fifo #(
      .TILE_X(3), .TILE_Y(0), .IDX(0), .DEPTH(8), .AF_SLACK(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rsp_en       (rsp_en),
      .rsp_data     (rsp_data),
      .rsp_addr     (rsp_addr),
      .rsp_sz       (rsp_sz),
      .rsp_stall    (rsp_stall),
      .lnk_in       (lnk_in),
      .lnk_in_full  (lnk_in_full),
      .lnk_out      (lnk_out),
      .lnk_out_full (lnk_out_full),
      .ack_valid    (ack_valid),
      .ack_ready    (ack_ready),
      .ack_data     (ack_data),
      .ack_addr     (ack_addr),
      .ack_sz       (ack_sz),
      .ovf_err      (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [122:0] mk_pkt(input logic [4:0] tx, input logic [4:0] ty,
                                           input logic [32:0] addr, input logic [73:0] data);
      logic [122:0] p;
      p          = '0;
      p[73:0]    = data;
      p[80:76]   = tx;
      p[85:81]   = ty;
      p[120:88]  = addr;
      p[121]     = 1'b1;
      return p;
   endfunction

   task automatic chk_idle(input string tag);
      check({tag, "_out0"},    128'(lnk_out[0]), 128'd0);
      check({tag, "_out1"},    128'(lnk_out[1]), 128'd0);
      check({tag, "_infull"},  128'(lnk_in_full), 128'd0);
      check({tag, "_stall"},   128'(rsp_stall), 128'd0);
      check({tag, "_avalid"},  128'(ack_valid), 128'd0);
      check({tag, "_adata"},   128'(ack_data), 128'd0);
      check({tag, "_aaddr"},   128'(ack_addr), 128'd0);
      check({tag, "_asz"},     128'(ack_sz), 128'd0);
      check({tag, "_ovf"},     128'(ovf_err), 128'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [73:0] exp_ord [6];

   initial begin
      rst = 1'b1; rsp_en = 1'b0; rsp_data = '0; rsp_addr = '0; rsp_sz = '0;
      lnk_in = '0; lnk_out_full = '0; ack_ready = 1'b0;
      tick();
      tick();
      chk_idle("rst");
      rst = 1'b0;
      tick();

      // 1: local ack to TX=5 goes forward with 3-cycle latency
      rsp_addr = {5'd0, 5'd5, 33'h0}; rsp_data = 74'h2A; rsp_sz = 2'd1; rsp_en = 1'b1;
      tick(); rsp_en = 1'b0;
      check("t1_snd_t1", 128'(lnk_out[1][121]), 128'd0);
      tick();
      check("t1_snd_t2", 128'(lnk_out[1][121]), 128'd0);
      tick();
      check("t1_snd_t3",  128'(lnk_out[1][121]), 128'd1);
      check("t1_tx",      128'(lnk_out[1][80:76]), 128'd5);
      check("t1_data",    128'(lnk_out[1][73:0]), 128'h2A);
      check("t1_xdone",   128'(lnk_out[1][74]), 128'd1);
      check("t1_ydone",   128'(lnk_out[1][75]), 128'd0);
      check("t1_sz",      128'(lnk_out[1][87:86]), 128'd1);
      check("t1_back",    128'(lnk_out[0][121]), 128'd0);
      tick();
      check("t1_snd_t4",  128'(lnk_out[1][121]), 128'd0);

      // 2: eject with a stalled consumer keeps fields stable
      lnk_in[0] = mk_pkt(5'd3, 5'd0, 33'h1234, 74'h77);
      tick(); lnk_in[0] = '0;
      check("t2_valid", 128'(ack_valid), 128'd1);
      check("t2_addr",  128'(ack_addr), 128'({5'd0, 5'd3, 33'h1234}));
      check("t2_data",  128'(ack_data), 128'h77);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t2_hold_valid%0d", i), 128'(ack_valid), 128'd1);
         check($sformatf("t2_hold_addr%0d", i), 128'(ack_addr[32:0]), 128'h1234);
      end
      ack_ready = 1'b1;
      tick(); ack_ready = 1'b0;
      check("t2_popped", 128'(ack_valid), 128'd0);

      // 3: backpressured forward link fills tq1 to the almost-full mark
      lnk_out_full[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lnk_in[0] = mk_pkt(5'd7, 5'd0, 33'(i), 74'(8'h10 + i));
         tick();
         check($sformatf("t3_infull%0d", i), 128'(lnk_in_full[0]), 128'(i == 5));
      end
      lnk_in[0] = '0;
      tick();
      check("t3_infull_hold", 128'(lnk_in_full[0]), 128'd1);
      check("t3_blocked",     128'(lnk_out[1][121]), 128'd0);
      check("t3_ovf",         128'(ovf_err), 128'd0);
      lnk_out_full[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t3_out_snd%0d", i),  128'(lnk_out[1][121]), 128'd1);
         check($sformatf("t3_out_data%0d", i), 128'(lnk_out[1][73:0]), 128'(8'h10 + i));
         if (i == 0) check("t3_infull_drop", 128'(lnk_in_full[0]), 128'd0);
      end
      tick();
      check("t3_drained", 128'(lnk_out[1][121]), 128'd0);

      // 4: transit and local collide on tq1; transit first
      rsp_addr = {5'd0, 5'd5, 33'h0}; rsp_data = 74'h55; rsp_sz = 2'd0; rsp_en = 1'b1;
      tick(); rsp_en = 1'b0;
      lnk_in[0] = mk_pkt(5'd6, 5'd0, 33'h0, 74'h66);
      #1 check("t4_stall1", 128'(rsp_stall), 128'd1);
      tick(); lnk_in[0] = '0;
      #1 check("t4_stall0", 128'(rsp_stall), 128'd0);
      tick();
      check("t4_first_snd",  128'(lnk_out[1][121]), 128'd1);
      check("t4_first_data", 128'(lnk_out[1][73:0]), 128'h66);
      tick();
      check("t4_second_snd",  128'(lnk_out[1][121]), 128'd1);
      check("t4_second_data", 128'(lnk_out[1][73:0]), 128'h55);

      // 5: round-robin between both eject queues
      do_reset();
      for (int i = 0; i < 3; i++) begin
         lnk_in[0] = mk_pkt(5'd3, 5'd0, 33'h0, 74'(8'hA0 + i));
         lnk_in[1] = mk_pkt(5'd3, 5'd0, 33'h0, 74'(8'hB0 + i));
         tick();
      end
      lnk_in = '0;
      ack_ready = 1'b1;
      exp_ord[0] = 74'hA0; exp_ord[1] = 74'hB0; exp_ord[2] = 74'hA1;
      exp_ord[3] = 74'hB1; exp_ord[4] = 74'hA2; exp_ord[5] = 74'hB2;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("t5_valid%0d", k), 128'(ack_valid), 128'd1);
         check($sformatf("t5_grant%0d", k), 128'(ack_data), 128'(exp_ord[k]));
         tick();
      end
      check("t5_empty", 128'(ack_valid), 128'd0);
      ack_ready = 1'b0;

      // 6: reset with all queues partly occupied
      lnk_out_full = 2'b11;
      for (int i = 0; i < 2; i++) begin
         lnk_in[0] = mk_pkt(5'd7, 5'd0, 33'h0, 74'(8'hC0 + i));
         lnk_in[1] = mk_pkt(5'd1, 5'd0, 33'h0, 74'(8'hD0 + i));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         lnk_in[0] = mk_pkt(5'd3, 5'd0, 33'h0, 74'(8'hE0 + i));
         lnk_in[1] = mk_pkt(5'd3, 5'd0, 33'h0, 74'(8'hF0 + i));
         rsp_addr = {5'd0, 5'd9, 33'h0}; rsp_data = 74'h99; rsp_en = (i == 0);
         tick();
      end
      lnk_in = '0; rsp_en = 1'b0;
      tick();
      check("t6_pre_valid", 128'(ack_valid), 128'd1);
      rst = 1'b1; lnk_out_full = 2'b00;
      tick();
      chk_idle("t6");
      rst = 1'b0;
      tick();
      check("t6_stale0", 128'(lnk_out[0][121]), 128'd0);
      check("t6_stale1", 128'(lnk_out[1][121]), 128'd0);
      check("t6_stale_ack", 128'(ack_valid), 128'd0);
      lnk_in[1] = mk_pkt(5'd1, 5'd0, 33'h0, 74'h31);
      lnk_in[0] = mk_pkt(5'd3, 5'd0, 33'h42, 74'h32);
      tick(); lnk_in = '0;
      check("t6_ej_valid", 128'(ack_valid), 128'd1);
      check("t6_ej_data",  128'(ack_data), 128'h32);
      check("t6_tr_t1",    128'(lnk_out[0][121]), 128'd0);
      tick();
      check("t6_tr_t2",    128'(lnk_out[0][121]), 128'd1);
      check("t6_tr_data",  128'(lnk_out[0][73:0]), 128'h31);
      check("t6_ovf",      128'(ovf_err), 128'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
